// File: rtl/dadda_mac_8x8.sv
// Pipelined 8x8 unsigned multiply-accumulate: operands -> dadda_8x8_compressed -> accumulator.
// Optional DADDA_MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.

module dadda_8x8_compressed (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    logic [15:0] pp [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = b_i[gi] ? (16'({8'd0, a_i}) << gi) : 16'd0;
        end
    endgenerate

    // 3:2 compressor on whole rows; returns {carry<<1, sum}
    function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
        logic [15:0] s;
        logic [15:0] c;
        s = x ^ y ^ z;
        c = (x & y) | (x & z) | (y & z);
        return {c[14:0], 1'b0, s};
    endfunction

    logic [31:0] l1_a, l1_b, l2_a, l2_b, l3_a, l4_a;

    assign l1_a = csa(pp[0], pp[1], pp[2]);
    assign l1_b = csa(pp[3], pp[4], pp[5]);
    assign l2_a = csa(l1_a[15:0], l1_a[31:16], l1_b[15:0]);
    assign l2_b = csa(l1_b[31:16], pp[6], pp[7]);
    assign l3_a = csa(l2_a[15:0], l2_a[31:16], l2_b[15:0]);
    assign l4_a = csa(l3_a[15:0], l3_a[31:16], l2_b[31:16]);
    assign p_o  = l4_a[15:0] + l4_a[31:16];
endmodule

module dadda_mac_8x8 #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t      state_q;
    logic [1:0]  drain_q;
    logic        in_ready_q, out_valid_q;
    logic [7:0]  a1_q, b1_q;
    logic        last1_q, v1_q;
    logic [15:0] p2_q;
    logic        last2_q, v2_q;
    logic [15:0] prod;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [ACC_W:0] sum;
    logic        accept, hold_exit;

    assign accept    = in_valid && in_ready_q;
    assign hold_exit = (state_q == HOLD) && out_ready;

    dadda_8x8_compressed u_mul (
        .a_i(a1_q),
        .b_i(b1_q),
        .p_o(prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                            drain_q    <= 2'd0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    // the group's last product lands in the accumulator on this edge
                    if (drain_q == 2'd1 && last2_q) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sum = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, p2_q};

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (hold_exit) begin
            acc_d   = '0;
            count_d = 8'd0;
            ovf_d   = 1'b0;
        end else if (v2_q) begin
`ifdef DADDA_MAC_SATURATE_EN
            acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            count_d = (count_q == 8'd255) ? 8'd255 : count_q + 8'd1;
            ovf_d   = ovf_q | sum[ACC_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1_q    <= 8'd0;
            b1_q    <= 8'd0;
            last1_q <= 1'b0;
            v1_q    <= 1'b0;
            p2_q    <= 16'd0;
            last2_q <= 1'b0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            count_q <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                a1_q    <= in_a;
                b1_q    <= in_b;
                last1_q <= in_last;
            end
            p2_q    <= prod;
            v2_q    <= v1_q;
            last2_q <= last1_q;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_dadda_mac_8x8.sv
// Directed bench for dadda_mac_8x8: a 24-bit and a 16-bit accumulator instance checked against a result queue.
module tb_dadda_mac_8x8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_a = 8'd0, in_b = 8'd0;
    logic        in_last = 1'b0;
    logic        vld24 = 1'b0, vld16 = 1'b0;
    logic        rdy24 = 1'b0, rdy16 = 1'b0;
    logic        in_ready24, in_ready16, out_valid24, out_valid16;
    logic [23:0] out_acc24;
    logic [15:0] out_acc16;
    logic [7:0]  out_count24, out_count16;
    logic        out_ovf24, out_ovf16;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t sb24[$];
    exp_t sb16[$];

    always #5 clk = ~clk;

    dadda_mac_8x8 #(.ACC_W(24)) u_dut (
        .clk(clk), .rst(rst), .in_valid(vld24), .in_ready(in_ready24),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid24), .out_ready(rdy24),
        .out_acc(out_acc24), .out_count(out_count24), .out_ovf(out_ovf24)
    );

    dadda_mac_8x8 #(.ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(vld16), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid16), .out_ready(rdy16),
        .out_acc(out_acc16), .out_count(out_count16), .out_ovf(out_ovf16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sel16, input logic [7:0] a, input logic [7:0] b, input logic last);
        in_a = a;
        in_b = b;
        in_last = last;
        if (sel16) vld16 = 1'b1; else vld24 = 1'b1;
        tick();
        vld16 = 1'b0;
        vld24 = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_valid(input bit sel16, input string tag);
        int n = 0;
        while (!(sel16 ? out_valid16 : out_valid24) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check({tag, "_timeout"}, 32'(sel16 ? out_valid16 : out_valid24), 32'd1);
    endtask

    task automatic collect(input bit sel16, input string tag);
        exp_t e;
        wait_valid(sel16, tag);
        e = sel16 ? sb16.pop_front() : sb24.pop_front();
        check({tag, "_acc"}, sel16 ? 32'(out_acc16) : 32'(out_acc24), e.acc);
        check({tag, "_cnt"}, 32'(sel16 ? out_count16 : out_count24), 32'(e.cnt));
        check({tag, "_ovf"}, 32'(sel16 ? out_ovf16 : out_ovf24), 32'(e.ovf));
        check({tag, "_rdy_hold"}, 32'(sel16 ? in_ready16 : in_ready24), 32'd0);
        $display("txn %s: acc=%0d count=%0d ovf=%0d", tag,
                 sel16 ? 32'(out_acc16) : 32'(out_acc24),
                 sel16 ? out_count16 : out_count24, sel16 ? out_ovf16 : out_ovf24);
        if (sel16) rdy16 = 1'b1; else rdy24 = 1'b1;
        tick();
        rdy16 = 1'b0;
        rdy24 = 1'b0;
        check({tag, "_exit_acc"}, sel16 ? 32'(out_acc16) : 32'(out_acc24), 32'd0);
        check({tag, "_exit_cnt"}, 32'(sel16 ? out_count16 : out_count24), 32'd0);
        check({tag, "_exit_ovf"}, 32'(sel16 ? out_ovf16 : out_ovf24), 32'd0);
        check({tag, "_exit_vld"}, 32'(sel16 ? out_valid16 : out_valid24), 32'd0);
        check({tag, "_exit_rdy"}, 32'(sel16 ? in_ready16 : in_ready24), 32'd1);
    endtask

    initial begin
        logic [23:0] h_acc;
        logic [7:0]  h_cnt;
        logic        h_ovf;

        // reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready24), 32'd1);
        check("rst_out_valid", 32'(out_valid24), 32'd0);
        check("rst_acc", 32'(out_acc24), 32'd0);
        check("rst_cnt", 32'(out_count24), 32'd0);
        check("rst_ovf", 32'(out_ovf24), 32'd0);

        // test 1: single 255x255, latency k+2
        sb24.push_back('{acc: 32'd65025, cnt: 8'd1, ovf: 1'b0});
        send(1'b0, 8'd255, 8'd255, 1'b1);
        check("t1_rdy_after_last", 32'(in_ready24), 32'd0);
        check("t1_vld_k", 32'(out_valid24), 32'd0);
        tick();
        check("t1_vld_k1", 32'(out_valid24), 32'd0);
        tick();
        check("t1_vld_k2", 32'(out_valid24), 32'd1);
        collect(1'b0, "t1");

        // test 2: gap of two idle cycles between terms
        sb24.push_back('{acc: 32'd98, cnt: 8'd3, ovf: 1'b0});
        send(1'b0, 8'd3, 8'd4, 1'b0);
        send(1'b0, 8'd5, 8'd6, 1'b0);
        tick();
        tick();
        check("t2_rdy_accum", 32'(in_ready24), 32'd1);
        send(1'b0, 8'd7, 8'd8, 1'b1);
        check("t2_rdy_drain", 32'(in_ready24), 32'd0);
        tick();
        check("t2_rdy_drain2", 32'(in_ready24), 32'd0);
        collect(1'b0, "t2");

        // test 3: backpressure in HOLD, in_valid ignored there
        sb24.push_back('{acc: 32'd2, cnt: 8'd1, ovf: 1'b0});
        send(1'b0, 8'd1, 8'd2, 1'b0);
        send(1'b0, 8'd0, 8'd9, 1'b1);
        sb24[sb24.size()-1].cnt = 8'd2;
        wait_valid(1'b0, "t3");
        h_acc = out_acc24;
        h_cnt = out_count24;
        h_ovf = out_ovf24;
        in_a = 8'd9;
        in_b = 8'd9;
        vld24 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_acc", 32'(out_acc24), 32'(h_acc));
            check("t3_hold_cnt", 32'(out_count24), 32'(h_cnt));
            check("t3_hold_ovf", 32'(out_ovf24), 32'(h_ovf));
            check("t3_hold_vld", 32'(out_valid24), 32'd1);
            check("t3_hold_rdy", 32'(in_ready24), 32'd0);
        end
        vld24 = 1'b0;
        collect(1'b0, "t3");

        // test 4: 16-bit accumulator overflow
`ifdef DADDA_MAC_SATURATE_EN
        sb16.push_back('{acc: 32'd65535, cnt: 8'd2, ovf: 1'b1});
`else
        sb16.push_back('{acc: 32'd64514, cnt: 8'd2, ovf: 1'b1});
`endif
        send(1'b1, 8'd255, 8'd255, 1'b0);
        send(1'b1, 8'd255, 8'd255, 1'b1);
        collect(1'b1, "t4");

        // test 5: count saturates at 255
        sb24.push_back('{acc: 32'd300, cnt: 8'd255, ovf: 1'b0});
        for (int i = 0; i < 300; i++) send(1'b0, 8'd1, 8'd1, (i == 299));
        collect(1'b0, "t5");

        // test 6: reset in the first DRAIN cycle
        send(1'b0, 8'd3, 8'd3, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_vld", 32'(out_valid24), 32'd0);
        check("t6_rst_acc", 32'(out_acc24), 32'd0);
        check("t6_rst_rdy", 32'(in_ready24), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t6_flushed_acc", 32'(out_acc24), 32'd0);
        check("t6_flushed_vld", 32'(out_valid24), 32'd0);
        sb24.push_back('{acc: 32'd4, cnt: 8'd1, ovf: 1'b0});
        send(1'b0, 8'd2, 8'd2, 1'b1);
        collect(1'b0, "t6");

        check("sb_empty", 32'(sb24.size() + sb16.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
